// File: rtl/sic_mem_pkg.sv
// Shared types and helpers for the parametrised SIC word memory.
// Request fields are sized for the widest supported configuration.
package sic_mem_pkg;

  localparam int unsigned BYTE_WIDTH        = 8;
  localparam int unsigned MAX_ADDRESS_WIDTH = 32;
  localparam int unsigned MAX_DATA_SIZE     = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic                         write;
    logic                         byte_mode;
    logic [MAX_ADDRESS_WIDTH-1:0] address;
    logic [MAX_DATA_SIZE-1:0]     wdata;
  } mem_req_t;

  // Address successor with wrap at the configured memory size, not the field width.
  function automatic logic [MAX_ADDRESS_WIDTH-1:0] next_addr(
    input logic [MAX_ADDRESS_WIDTH-1:0] addr,
    input logic [MAX_ADDRESS_WIDTH-1:0] size
  );
    return (addr == size - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/sic_byte_ram.sv
// Single-port byte array: combinational read, synchronous write.
// Kept separate so a technology macro can replace it.
module sic_byte_ram
  import sic_mem_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE   = 32768,
  parameter int unsigned ADDRESS_WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [BYTE_WIDTH-1:0]    wdata,
  output logic [BYTE_WIDTH-1:0]    rdata
);

  logic [BYTE_WIDTH-1:0] mem [MEMORY_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sic_word_memory.sv
// SIC main memory with configurable word size: valid/ready request and
// response, byte-serial big-endian access, modulo-size wrap, range error.
module sic_word_memory
  import sic_mem_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE    = 32768,
  parameter int unsigned ADDRESS_WIDTH  = 15,
  parameter int unsigned BYTES_PER_WORD = 3,
  parameter int unsigned DATA_SIZE      = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_byte,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_SIZE-1:0]     req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_SIZE-1:0]     rsp_rdata,
  output logic                     rsp_error
);

  if (DATA_SIZE != BYTE_WIDTH * BYTES_PER_WORD) begin : g_bad_data_size
    $error("DATA_SIZE must equal 8*BYTES_PER_WORD");
  end
  if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 8) begin : g_bad_word
    $error("BYTES_PER_WORD must be in 1..8");
  end
  if (ADDRESS_WIDTH > MAX_ADDRESS_WIDTH || MEMORY_SIZE < BYTES_PER_WORD ||
      MEMORY_SIZE > (64'd1 << ADDRESS_WIDTH)) begin : g_bad_size
    $error("MEMORY_SIZE/ADDRESS_WIDTH out of range");
  end

  localparam int unsigned CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(BYTES_PER_WORD - 1);

  state_t                state_q, state_d;
  mem_req_t              req_q;
  logic [CNT_W-1:0]      k_q;
  logic [DATA_SIZE-1:0]  shift_q;
  logic                  err_q;
  logic                  req_oob;
  logic                  last_byte;
  logic                  ram_we;
  logic [BYTE_WIDTH-1:0] ram_rdata;

  assign req_oob   = 32'(req_address) >= 32'(MEMORY_SIZE);
  assign last_byte = req_q.byte_mode || (k_q == LAST_K);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = req_oob ? RESP : ACCESS;
      ACCESS:  if (last_byte) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = req_q.write ? '0 : shift_q;
    rsp_error = err_q;
    ram_we    = (state_q == ACCESS) && req_q.write;
  end

  // Write data is held MSB-aligned and shifted up one byte per access, so the
  // byte to store is always the top byte; byte mode pre-aligns wdata[7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      k_q     <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q.write     <= req_write;
            req_q.byte_mode <= req_byte;
            req_q.address   <= 32'(req_address);
            req_q.wdata     <= req_byte
              ? (MAX_DATA_SIZE'(req_wdata[BYTE_WIDTH-1:0]) << (MAX_DATA_SIZE - BYTE_WIDTH))
              : (MAX_DATA_SIZE'(req_wdata) << (MAX_DATA_SIZE - DATA_SIZE));
            k_q             <= '0;
            shift_q         <= '0;
            err_q           <= req_oob;
          end
        end
        ACCESS: begin
          k_q           <= k_q + CNT_W'(1);
          req_q.address <= next_addr(req_q.address, 32'(MEMORY_SIZE));
          req_q.wdata   <= req_q.wdata << BYTE_WIDTH;
          if (!req_q.write) begin
            shift_q <= (shift_q << BYTE_WIDTH) | DATA_SIZE'(ram_rdata);
          end
        end
        RESP: begin
          if (rsp_ready) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  sic_byte_ram #(
    .MEMORY_SIZE  (MEMORY_SIZE),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (req_q.address[ADDRESS_WIDTH-1:0]),
    .wdata(req_q.wdata[MAX_DATA_SIZE-1 -: BYTE_WIDTH]),
    .rdata(ram_rdata)
  );

endmodule
